dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single data_mem port between the datapath (requester A) and a debug/DMA loader (requester B). It issues combinational grants from registered round-robin state, drives data_mem's read/write port for the granted requester, and returns read data registered one cycle later. It sits between Datapath/loader and data_mem inside cpu.

---
 rtl/dmem_arbiter_pkg.sv | 28 ++
 rtl/dmem_arbiter_if.sv | 33 +++
 rtl/dmem_arbiter_rr_arb2.sv | 96 +++++++++
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default bus widths, requester IDs, pending-read encoding and the
// round-robin tie-break helper.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 32;
    localparam int STRB_W_DEF = 3;

    // Requester IDs, also the encoding of last_gnt.
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // Which requester (if any) owns the read data captured on the last edge.
    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_A    = 2'd1,
        PEND_B    = 2'd2
    } pend_rd_e;

    // Plain round-robin: on a tie the requester that was not served last wins.
    function automatic logic rr_tie_winner(input logic last_gnt);
        return ~last_gnt;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter (one instance per requester).
// Latency: grant is combinational; rvalid/rdata arrive one cycle after a read grant.
// Backpressure: requester holds req and its fields stable until gnt is seen.
// Signals: req/we/addr/wdata/strb from the requester; gnt/rvalid/rdata back to it.
// Modports: master = requester side, slave = arbiter side.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int STRB_W = STRB_W_DEF
) ();

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata, strb,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, strb,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant logic with registered last-grant state.
// Latency: grants are combinational from req and registered state; state updates on clk.
// Backpressure: a losing requester simply sees no grant and keeps its request up.
// Ports: i_clk, i_rst (sync, active-high), i_req_a/i_req_b, o_gnt_a/o_gnt_b;
// with DMEM_ARB_LOCK_EN also i_lock_a/i_lock_b (lock holds ties for up to MAX_LOCK grants).
module rr_arb2
    import dmem_arb_pkg::*;
`ifdef DMEM_ARB_LOCK_EN
#(
    parameter int MAX_LOCK = 4
)
`endif
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_a,
    input  logic i_req_b,
`ifdef DMEM_ARB_LOCK_EN
    input  logic i_lock_a,
    input  logic i_lock_b,
`endif
    output logic o_gnt_a,
    output logic o_gnt_b
);

    logic r_last_gnt;
    logic w_tie_win;
    logic w_any_gnt;
    logic w_gnt_id;

    assign w_any_gnt = o_gnt_a | o_gnt_b;
    assign w_gnt_id  = o_gnt_b ? REQ_B : REQ_A;

`ifdef DMEM_ARB_LOCK_EN
    localparam int               LCW      = $clog2(MAX_LOCK + 1);
    localparam logic [LCW-1:0]   LOCK_MAX = LCW'(MAX_LOCK);

    // Consecutive grants the current owner has taken while holding lock.
    logic [LCW-1:0] r_lock_cnt;
    logic           w_last_lock;
    logic           w_owner_hold;
    logic           w_gnt_lock;

    assign w_last_lock  = (r_last_gnt == REQ_B) ? i_lock_b : i_lock_a;
    assign w_owner_hold = w_last_lock & ((r_last_gnt == REQ_B) ? i_req_b : i_req_a);
    assign w_gnt_lock   = o_gnt_b ? i_lock_b : i_lock_a;
`endif

    always_comb begin
        w_tie_win = rr_tie_winner(r_last_gnt);
`ifdef DMEM_ARB_LOCK_EN
        // A locked owner keeps ties until it has used up its MAX_LOCK run.
        if (w_owner_hold && (r_lock_cnt < LOCK_MAX)) begin
            w_tie_win = r_last_gnt;
        end
`endif
        o_gnt_a = 1'b0;
        o_gnt_b = 1'b0;
        if (i_req_a && i_req_b) begin
            o_gnt_a = (w_tie_win == REQ_A);
            o_gnt_b = (w_tie_win == REQ_B);
        end else begin
            o_gnt_a = i_req_a;
            o_gnt_b = i_req_b;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // B counts as last served so that A wins the first tie.
            r_last_gnt <= REQ_B;
        end else if (w_any_gnt) begin
            r_last_gnt <= w_gnt_id;
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lock_cnt <= '0;
        end else if (w_any_gnt) begin
            if (!w_gnt_lock) begin
                r_lock_cnt <= '0;
            end else if (w_gnt_id != r_last_gnt) begin
                // New owner starts its run with this grant.
                r_lock_cnt <= LCW'(1);
            end else if (r_lock_cnt != LOCK_MAX) begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end
        end else if (!w_last_lock) begin
            r_lock_cnt <= '0;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data_mem port between the datapath (A) and the debug/DMA loader (B).
// Latency: grant and memory-port drive are combinational; read data returns one cycle after grant.
// Backpressure: losing requester holds its request; a grant always completes in its cycle.
// Ports: clk, rst (sync, active-high); a_if/b_if requester buses; mem_* drive data_mem
// (mem_rd_dout0 is its combinational read data); a_gnt_cnt/b_gnt_cnt saturating grant counts.
// Optional feature DMEM_ARB_LOCK_EN adds a_lock/b_lock inputs and the MAX_LOCK parameter.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int STRB_W = STRB_W_DEF,
    parameter int CNT_W  = 16
`ifdef DMEM_ARB_LOCK_EN
    ,
    parameter int MAX_LOCK = 4
`endif
) (
    input  logic                clk,
    input  logic                rst,
    dmem_arbiter_if.slave       a_if,
    dmem_arbiter_if.slave       b_if,
`ifdef DMEM_ARB_LOCK_EN
    input  logic                a_lock,
    input  logic                b_lock,
`endif
    output logic                mem_we0,
    output logic [ADDR_W-1:0]   mem_rd_addr0,
    output logic [ADDR_W-1:0]   mem_wr_addr0,
    output logic [DATA_W-1:0]   mem_wr_din0,
    output logic [STRB_W-1:0]   mem_wr_strb,
    input  logic [DATA_W-1:0]   mem_rd_dout0,
    output logic [CNT_W-1:0]    a_gnt_cnt,
    output logic [CNT_W-1:0]    b_gnt_cnt
);

    logic              w_gnt_a;
    logic              w_gnt_b;
    logic              w_rd_a;
    logic              w_rd_b;
    pend_rd_e          r_pend_rd;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;
    logic [CNT_W-1:0]  r_a_cnt;
    logic [CNT_W-1:0]  r_b_cnt;

    rr_arb2
`ifdef DMEM_ARB_LOCK_EN
    #(
        .MAX_LOCK (MAX_LOCK)
    )
`endif
    u_rr_arb2 (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req_a  (a_if.req),
        .i_req_b  (b_if.req),
`ifdef DMEM_ARB_LOCK_EN
        .i_lock_a (a_lock),
        .i_lock_b (b_lock),
`endif
        .o_gnt_a  (w_gnt_a),
        .o_gnt_b  (w_gnt_b)
    );

    assign a_if.gnt = w_gnt_a;
    assign b_if.gnt = w_gnt_b;

    assign w_rd_a = w_gnt_a & ~a_if.we;
    assign w_rd_b = w_gnt_b & ~b_if.we;

    // Memory port mux: everything is zero when nobody is granted.
    // Writes are blocked during reset even though grants still follow req.
    always_comb begin
        mem_we0      = 1'b0;
        mem_rd_addr0 = '0;
        mem_wr_addr0 = '0;
        mem_wr_din0  = '0;
        mem_wr_strb  = '0;
        if (w_gnt_a) begin
            mem_we0      = a_if.we & ~rst;
            mem_rd_addr0 = a_if.addr;
            mem_wr_addr0 = a_if.addr;
            mem_wr_din0  = a_if.wdata;
            mem_wr_strb  = a_if.strb;
        end else if (w_gnt_b) begin
            mem_we0      = b_if.we & ~rst;
            mem_rd_addr0 = b_if.addr;
            mem_wr_addr0 = b_if.addr;
            mem_wr_din0  = b_if.wdata;
            mem_wr_strb  = b_if.strb;
        end
    end

    // Read return path: pend_rd marks whose data was captured on the last edge,
    // so each read grant produces exactly one rvalid cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_rd <= PEND_NONE;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            if (w_rd_a) begin
                r_pend_rd <= PEND_A;
            end else if (w_rd_b) begin
                r_pend_rd <= PEND_B;
            end else begin
                r_pend_rd <= PEND_NONE;
            end
            if (w_rd_a) begin
                r_a_rdata <= mem_rd_dout0;
            end
            if (w_rd_b) begin
                r_b_rdata <= mem_rd_dout0;
            end
        end
    end

    assign a_if.rvalid = (r_pend_rd == PEND_A);
    assign b_if.rvalid = (r_pend_rd == PEND_B);
    assign a_if.rdata  = r_a_rdata;
    assign b_if.rdata  = r_b_rdata;

    // Grant counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_cnt <= '0;
            r_b_cnt <= '0;
        end else begin
            if (w_gnt_a && (r_a_cnt != '1)) begin
                r_a_cnt <= r_a_cnt + 1'b1;
            end
            if (w_gnt_b && (r_b_cnt != '1)) begin
                r_b_cnt <= r_b_cnt + 1'b1;
            end
        end
    end

    assign a_gnt_cnt = r_a_cnt;
    assign b_gnt_cnt = r_b_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural data_mem.
// Counters are built 4 bits wide so saturation is reachable in a short run.
// Lock checks are compiled in only when DMEM_ARB_LOCK_EN is defined.
module tb_dmem_arbiter;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int STRB_W = 3;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              mem_we0;
    logic [ADDR_W-1:0] mem_rd_addr0;
    logic [ADDR_W-1:0] mem_wr_addr0;
    logic [DATA_W-1:0] mem_wr_din0;
    logic [STRB_W-1:0] mem_wr_strb;
    logic [DATA_W-1:0] mem_rd_dout0;
    logic [CNT_W-1:0]  a_gnt_cnt;
    logic [CNT_W-1:0]  b_gnt_cnt;
`ifdef DMEM_ARB_LOCK_EN
    logic              a_lock;
    logic              b_lock;
`endif

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) a_if ();
    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) b_if ();

    dmem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .STRB_W (STRB_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .a_if         (a_if),
        .b_if         (b_if),
`ifdef DMEM_ARB_LOCK_EN
        .a_lock       (a_lock),
        .b_lock       (b_lock),
`endif
        .mem_we0      (mem_we0),
        .mem_rd_addr0 (mem_rd_addr0),
        .mem_wr_addr0 (mem_wr_addr0),
        .mem_wr_din0  (mem_wr_din0),
        .mem_wr_strb  (mem_wr_strb),
        .mem_rd_dout0 (mem_rd_dout0),
        .a_gnt_cnt    (a_gnt_cnt),
        .b_gnt_cnt    (b_gnt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data_mem: combinational read, full-word write on the clock.
    assign mem_rd_dout0 = mem[mem_rd_addr0];

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[3] = 32'h3333_3333;
        mem[5] = 32'h5555_5555;
        forever begin
            @(posedge clk);
            if (mem_we0) mem[mem_wr_addr0] <= mem_wr_din0;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [STRB_W-1:0] strb);
        a_if.req = req; a_if.we = we; a_if.addr = addr; a_if.wdata = wdata; a_if.strb = strb;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [STRB_W-1:0] strb);
        b_if.req = req; b_if.we = we; b_if.addr = addr; b_if.wdata = wdata; b_if.strb = strb;
    endtask

    initial begin
        rst = 1'b1;
`ifdef DMEM_ARB_LOCK_EN
        a_lock = 1'b0;
        b_lock = 1'b0;
`endif
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        #2;

        // Reset state, nobody requesting.
        check("rst_a_rvalid", a_if.rvalid, 0);
        check("rst_b_rvalid", b_if.rvalid, 0);
        check("rst_a_rdata", a_if.rdata, 0);
        check("rst_b_rdata", b_if.rdata, 0);
        check("rst_a_cnt", a_gnt_cnt, 0);
        check("rst_b_cnt", b_gnt_cnt, 0);
        check("idle_a_gnt", a_if.gnt, 0);
        check("idle_b_gnt", b_if.gnt, 0);
        check("idle_we", mem_we0, 0);
        check("idle_rdaddr", mem_rd_addr0, 0);
        check("idle_din", mem_wr_din0, 0);

        // Both read every cycle: A, B, A.
        set_a(1, 0, 3, 0, 0);
        set_b(1, 0, 5, 0, 0);
        #2;
        check("rr0_a_gnt", a_if.gnt, 1);
        check("rr0_b_gnt", b_if.gnt, 0);
        check("rr0_rdaddr", mem_rd_addr0, 3);
        check("rr0_wraddr", mem_wr_addr0, 3);
        tick();
        check("rr0_a_rvalid", a_if.rvalid, 1);
        check("rr0_a_rdata", a_if.rdata, 32'h3333_3333);
        check("rr0_b_rvalid", b_if.rvalid, 0);
        #2;
        check("rr1_a_gnt", a_if.gnt, 0);
        check("rr1_b_gnt", b_if.gnt, 1);
        check("rr1_rdaddr", mem_rd_addr0, 5);
        tick();
        check("rr1_b_rvalid", b_if.rvalid, 1);
        check("rr1_b_rdata", b_if.rdata, 32'h5555_5555);
        check("rr1_a_rvalid", a_if.rvalid, 0);
        check("rr1_a_rdata_hold", a_if.rdata, 32'h3333_3333);
        #2;
        check("rr2_a_gnt", a_if.gnt, 1);
        check("rr2_b_gnt", b_if.gnt, 0);
        tick();
        check("rr2_a_rvalid", a_if.rvalid, 1);
        check("rr2_b_rvalid", b_if.rvalid, 0);
        check("rr2_a_cnt", a_gnt_cnt, 2);
        check("rr2_b_cnt", b_gnt_cnt, 1);

        // B writes, then A reads the same word back.
        set_a(0, 0, 0, 0, 0);
        set_b(1, 1, 9, 32'hDEAD_BEEF, 3'b010);
        #2;
        check("wr_b_gnt", b_if.gnt, 1);
        check("wr_a_gnt", a_if.gnt, 0);
        check("wr_we", mem_we0, 1);
        check("wr_wraddr", mem_wr_addr0, 9);
        check("wr_rdaddr", mem_rd_addr0, 9);
        check("wr_din", mem_wr_din0, 32'hDEAD_BEEF);
        check("wr_strb", mem_wr_strb, 3'b010);
        tick();
        check("wr_b_rvalid", b_if.rvalid, 0);
        set_b(0, 0, 0, 0, 0);
        set_a(1, 0, 9, 0, 0);
        #2;
        check("rb_a_gnt", a_if.gnt, 1);
        check("rb_we", mem_we0, 0);
        tick();
        check("rb_a_rvalid", a_if.rvalid, 1);
        check("rb_a_rdata", a_if.rdata, 32'hDEAD_BEEF);
        check("rb_a_cnt", a_gnt_cnt, 3);
        check("rb_b_cnt", b_gnt_cnt, 2);

        // Reset with A active: grants follow req, writes are blocked, rvalid suppressed.
        rst = 1'b1;
        set_a(1, 1, 20, 32'h1234_5678, 3'b010);
        #2;
        check("rstw_a_gnt", a_if.gnt, 1);
        check("rstw_we", mem_we0, 0);
        tick();
        set_a(1, 0, 3, 0, 0);
        #2;
        check("rstr_a_gnt", a_if.gnt, 1);
        tick();
        rst = 1'b0;
        check("rstr_a_rvalid", a_if.rvalid, 0);
        check("rstr_a_rdata", a_if.rdata, 0);
        check("rstr_a_cnt", a_gnt_cnt, 0);
        check("rstr_b_cnt", b_gnt_cnt, 0);
        check("rstw_mem20", mem[20], 0);

        // A alone for 5 cycles.
        set_a(1, 0, 5, 0, 0);
        for (int i = 0; i < 5; i++) begin
            #2;
            check("aonly_a_gnt", a_if.gnt, 1);
            check("aonly_b_gnt", b_if.gnt, 0);
            tick();
        end
        check("aonly_a_cnt", a_gnt_cnt, 5);
        check("aonly_b_cnt", b_gnt_cnt, 0);
        check("aonly_a_rvalid", a_if.rvalid, 1);
        check("aonly_a_rdata", a_if.rdata, 32'h5555_5555);

        // Push A to 15 grants, then 2 more: counter must stick at 15.
        repeat (10) tick();
        check("sat15_a_cnt", a_gnt_cnt, 15);
        #2;
        check("sat_a_gnt", a_if.gnt, 1);
        repeat (2) tick();
        check("sat17_a_cnt", a_gnt_cnt, 15);
        check("sat17_b_cnt", b_gnt_cnt, 0);

        // Idle leaves last grant at A, so the next tie goes to B.
        set_a(0, 0, 0, 0, 0);
        #2;
        check("idle2_a_gnt", a_if.gnt, 0);
        check("idle2_we", mem_we0, 0);
        tick();
        check("idle2_a_rvalid", a_if.rvalid, 0);
        set_a(1, 0, 3, 0, 0);
        set_b(1, 0, 5, 0, 0);
        #2;
        check("tie_b_gnt", b_if.gnt, 1);
        check("tie_a_gnt", a_if.gnt, 0);
        tick();
        check("tie2_a_gnt", a_if.gnt, 1);
        check("tie2_b_gnt", b_if.gnt, 0);
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        tick();

`ifdef DMEM_ARB_LOCK_EN
        // A locked: four consecutive A grants, then B is forced in.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_lock = 1'b1;
        set_a(1, 0, 3, 0, 0);
        set_b(1, 0, 5, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #2;
            check("lock_a_gnt", a_if.gnt, 1);
            check("lock_b_gnt", b_if.gnt, 0);
            tick();
        end
        #2;
        check("lock_force_b_gnt", b_if.gnt, 1);
        check("lock_force_a_gnt", a_if.gnt, 0);
        tick();
        check("lock_a_cnt", a_gnt_cnt, 4);
        check("lock_b_cnt", b_gnt_cnt, 1);
        a_lock = 1'b0;
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
